// File: rtl/awg_pwm_dac.sv
// rtl/awg_pwm_dac.sv - double-buffered PWM output stage; define AWG_PWM_DAC_SD_EN to add the sigma-delta output
module awg_pwm_dac #(
   parameter int WIDTH    = 10,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   input  logic             enable,
   output logic             pwm_out,
   output logic             pdm_out,
   output logic             period_start,
   output logic             overrun
);

   // Prescaler terminal value; PRESCALE=256 maps onto the full 8-bit range.
   localparam logic [7:0]       PRESC_LAST = 8'(PRESCALE - 1);
   localparam logic [7:0]       PRESC_ONE  = 8'd1;
   localparam logic [WIDTH-1:0] CNT_LAST   = '1;
   localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

   logic [7:0]       presc_q, presc_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             pending_q, pending_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic             pwm_q, pwm_d;
   logic             period_start_q, period_start_d;
   logic             overrun_q, overrun_d;

   logic tick;
   logic transfer;
   logic consume;

   // Timing events: a PWM tick, the last tick of a period, and whether the
   // held sample is moved into the active register this cycle. While the
   // stage is stopped, any pending sample is taken over immediately so the
   // next run starts with the latest value.
   always_comb begin
      tick     = enable && (presc_q == PRESC_LAST);
      transfer = tick && (cnt_q == CNT_LAST);
      consume  = pending_q && (transfer || !enable);
   end

   // Prescaler and period counter; both parked at zero while disabled so a
   // fresh period begins at cnt=0 when enable rises.
   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         presc_d = '0;
         cnt_d   = '0;
      end else if (tick) begin
         presc_d = '0;
         cnt_d   = cnt_q + CNT_ONE;
      end else begin
         presc_d = presc_q + PRESC_ONE;
      end
   end

   // Double buffer: a transfer reads the old hold value, then a capture in
   // the same cycle refills hold and re-arms pending.
   always_comb begin
      hold_d    = hold_q;
      pending_d = pending_q;
      active_d  = active_q;
      if (consume) begin
         active_d  = hold_q;
         pending_d = 1'b0;
      end
      if (sample_valid) begin
         hold_d    = sample_in;
         pending_d = 1'b1;
      end
   end

   // Registered outputs: duty compare, period strobe and overwrite strobe.
   always_comb begin
      pwm_d          = enable && (cnt_q < active_q);
      period_start_d = transfer;
      overrun_d      = sample_valid && pending_q && !consume;
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q        <= '0;
         cnt_q          <= '0;
         hold_q         <= '0;
         pending_q      <= 1'b0;
         active_q       <= '0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         hold_q         <= hold_d;
         pending_q      <= pending_d;
         active_q       <= active_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
         overrun_q      <= overrun_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign overrun      = overrun_q;

`ifdef AWG_PWM_DAC_SD_EN
   // First-order sigma-delta: the top accumulator bit holds the carry of the
   // latest sum and is the registered bitstream itself.
   logic [WIDTH:0] acc_q, acc_d;
   logic [WIDTH:0] sd_sum;

   // Accumulate the active sample once per tick; cleared while disabled.
   always_comb begin
      sd_sum = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, active_q};
      acc_d  = acc_q;
      if (!enable) begin
         acc_d = '0;
      end else if (tick) begin
         acc_d = sd_sum;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign pdm_out = acc_q[WIDTH];
`else
   assign pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_awg_pwm_dac.sv
// tb/tb_awg_pwm_dac.sv - self-checking bench for awg_pwm_dac
module tb_awg_pwm_dac;

`ifdef AWG_PWM_DAC_SD_EN
   localparam bit SD_EN = 1'b1;
`else
   localparam bit SD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sample_in, sample_in4;
   logic       sample_valid, sample_valid4;
   logic       enable, enable4;
   logic       pwm_out, pdm_out, period_start, overrun;
   logic       pwm_out4, pdm_out4, period_start4, overrun4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   awg_pwm_dac #(.WIDTH(10), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .enable(enable), .pwm_out(pwm_out), .pdm_out(pdm_out),
      .period_start(period_start), .overrun(overrun)
   );

   awg_pwm_dac #(.WIDTH(10), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .sample_in(sample_in4), .sample_valid(sample_valid4),
      .enable(enable4), .pwm_out(pwm_out4), .pdm_out(pdm_out4),
      .period_start(period_start4), .overrun(overrun4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ps(input int limit, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < limit) begin
         step();
         n++;
         if (period_start) ok = 1'b1;
      end
   endtask

   // Runs one 1024-cycle period of the PRESCALE=1 instance, starting in the
   // cycle where period_start is seen, optionally loading up to two samples
   // at given offsets. Ends in the next period_start cycle.
   task automatic run_period(input int at1, input int v1, input int at2, input int v2,
                             output int highs, output int ovr, output bit ps_ok);
      highs = 0;
      ovr   = 0;
      ps_ok = 1'b1;
      for (int off = 0; off < 1024; off++) begin
         if (pwm_out) highs++;
         if (overrun) ovr++;
         if (off > 0 && period_start) ps_ok = 1'b0;
         sample_valid = 1'b0;
         if (off == at1) begin sample_valid = 1'b1; sample_in = v1[9:0]; end
         if (off == at2) begin sample_valid = 1'b1; sample_in = v2[9:0]; end
         step();
      end
      sample_valid = 1'b0;
      if (!period_start) ps_ok = 1'b0;
   endtask

   // One 4096-cycle window of the PRESCALE=4 instance after enable rises.
   task automatic measure4(output int highs, output int ps_cnt, output int last_ps);
      highs   = 0;
      ps_cnt  = 0;
      last_ps = -1;
      for (int e = 1; e <= 4096; e++) begin
         step();
         if (pwm_out4) highs++;
         if (period_start4) begin ps_cnt++; last_ps = e; end
      end
   endtask

   task automatic test_reset();
      int n, highs, ovr;
      bit ok;
      checks++;
      if ({pwm_out, pdm_out, period_start, overrun, pwm_out4, pdm_out4, period_start4, overrun4} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {pwm_out, pdm_out, period_start, overrun, pwm_out4, pdm_out4, period_start4, overrun4});
      end
      enable = 1'b1;
      sample_valid = 1'b1; sample_in = 10'd600;
      step();
      sample_valid = 1'b0;
      wait_ps(1100, n, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL first_period_start: got none expected within 1100 cycles"); end
      repeat (100) step();
      checks++;
      if (pwm_out !== 1'b1) begin errors++; $display("FAIL pwm_before_reset: got %b expected 1", pwm_out); end
      sample_valid = 1'b1; sample_in = 10'd300;
      step();
      sample_valid = 1'b0;
      rst = 1'b1;
      #2;
      checks++;
      if ({pwm_out, pdm_out, period_start, overrun} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset_outputs: got %b expected 0000", {pwm_out, pdm_out, period_start, overrun});
      end
      step();
      rst = 1'b0;
      wait_ps(2000, n, ok);
      checks++;
      if (!ok || n != 1024) begin
         errors++;
         $display("FAIL reset_to_period_start: got %0d cycles (seen=%0d) expected 1024", n, ok);
      end
      run_period(-1, 0, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != 0) begin errors++; $display("FAIL pending_discarded: got %0d high cycles expected 0", highs); end
   endtask

   task automatic test_duty();
      int vals[4];
      int highs, ovr;
      bit ok;
      vals[0] = 256;
      vals[1] = int'($urandom_range(1, 1022));
      vals[2] = 1023;
      vals[3] = 0;
      foreach (vals[i]) begin
         run_period(3, vals[i], -1, 0, highs, ovr, ok);
         run_period(-1, 0, -1, 0, highs, ovr, ok);
         checks++;
         if (highs != vals[i]) begin
            errors++;
            $display("FAIL duty_high[%0d]: got %0d expected %0d", i, highs, vals[i]);
         end
         checks++;
         if (!ok) begin errors++; $display("FAIL duty_period[%0d]: got period_start off-boundary expected 1024-cycle period", i); end
         checks++;
         if (ovr != 0) begin errors++; $display("FAIL duty_overrun[%0d]: got %0d expected 0", i, ovr); end
      end
   endtask

   task automatic test_update_boundary();
      int highs, ovr, a, b;
      bit ok;
      run_period(5, 256, -1, 0, highs, ovr, ok);
      run_period(100, 768, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != 256) begin errors++; $display("FAIL update_current: got %0d expected 256", highs); end
      run_period(-1, 0, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != 768) begin errors++; $display("FAIL update_next: got %0d expected 768", highs); end
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      run_period(5, a, -1, 0, highs, ovr, ok);
      run_period(int'($urandom_range(1, 1000)), b, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != a) begin errors++; $display("FAIL update_rand_current: got %0d expected %0d", highs, a); end
      run_period(-1, 0, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != b) begin errors++; $display("FAIL update_rand_next: got %0d expected %0d", highs, b); end
   endtask

   task automatic test_overrun();
      int highs, ovr, a, b, c, d;
      bit ok;
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      c = int'($urandom_range(0, 1023));
      d = int'($urandom_range(0, 1023));
      run_period(10, a, 15, b, highs, ovr, ok);
      checks++;
      if (ovr != 1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", ovr); end
      run_period(500, c, 1023, d, highs, ovr, ok);
      checks++;
      if (highs != b) begin errors++; $display("FAIL overrun_newer_wins: got %0d expected %0d", highs, b); end
      checks++;
      if (ovr != 0) begin errors++; $display("FAIL overrun_spurious: got %0d expected 0", ovr); end
      run_period(-1, 0, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != c) begin errors++; $display("FAIL coincident_old_hold: got %0d expected %0d", highs, c); end
      checks++;
      if (ovr != 0) begin errors++; $display("FAIL coincident_overrun: got %0d expected 0", ovr); end
      run_period(-1, 0, -1, 0, highs, ovr, ok);
      checks++;
      if (highs != d) begin errors++; $display("FAIL coincident_new_pending: got %0d expected %0d", highs, d); end
   endtask

   task automatic test_prescale();
      int highs, ps_cnt, last_ps, bad, s4, s5;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if ({pwm_out4, pdm_out4, period_start4, overrun4} != 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL disabled_idle: got %0d non-zero cycles expected 0", bad); end
      s4 = int'($urandom_range(1, 1023));
      sample_valid4 = 1'b1; sample_in4 = s4[9:0];
      step();
      sample_valid4 = 1'b0;
      step();
      enable4 = 1'b1;
      measure4(highs, ps_cnt, last_ps);
      checks++;
      if (highs != 4 * s4) begin errors++; $display("FAIL presc_high: got %0d expected %0d", highs, 4 * s4); end
      checks++;
      if (ps_cnt != 1 || last_ps != 4096) begin
         errors++;
         $display("FAIL presc_period: got %0d strobes last at %0d expected 1 at 4096", ps_cnt, last_ps);
      end
      repeat (1000) step();
      enable4 = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if ({pwm_out4, pdm_out4, period_start4, overrun4} != 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL enable_low_outputs: got %0d non-zero cycles expected 0", bad); end
      s5 = int'($urandom_range(1, 1023));
      sample_valid4 = 1'b1; sample_in4 = s5[9:0];
      step();
      sample_valid4 = 1'b0;
      step();
      enable4 = 1'b1;
      measure4(highs, ps_cnt, last_ps);
      checks++;
      if (highs != 4 * s5) begin errors++; $display("FAIL reenable_high: got %0d expected %0d", highs, 4 * s5); end
      checks++;
      if (ps_cnt != 1 || last_ps != 4096) begin
         errors++;
         $display("FAIL reenable_period: got %0d strobes last at %0d expected 1 at 4096", ps_cnt, last_ps);
      end
      measure4(highs, ps_cnt, last_ps);
      checks++;
      if (highs != 4 * s5 || ps_cnt != 1 || last_ps != 4096) begin
         errors++;
         $display("FAIL presc_steady: got high=%0d strobes=%0d last=%0d expected high=%0d strobes=1 last=4096",
                  highs, ps_cnt, last_ps, 4 * s5);
      end
   endtask

   task automatic test_sd();
      int highs, ovr, n, ones, trans, r;
      bit ok;
      logic prev;
      run_period(5, 512, -1, 0, highs, ovr, ok);
      step();
      prev  = pdm_out;
      ones  = 0;
      trans = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (pdm_out) ones++;
         if (pdm_out !== prev) trans++;
         prev = pdm_out;
      end
      checks++;
      if (ones != (SD_EN ? 16 : 0) || trans != (SD_EN ? 32 : 0)) begin
         errors++;
         $display("FAIL sd_half: got ones=%0d toggles=%0d expected ones=%0d toggles=%0d",
                  ones, trans, SD_EN ? 16 : 0, SD_EN ? 32 : 0);
      end
      r = int'($urandom_range(1, 1023));
      sample_valid = 1'b1; sample_in = r[9:0];
      step();
      sample_valid = 1'b0;
      wait_ps(1100, n, ok);
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         if (pdm_out) ones++;
      end
      checks++;
      if (ones != (SD_EN ? r : 0)) begin
         errors++;
         $display("FAIL sd_density: got %0d ones expected %0d", ones, SD_EN ? r : 0);
      end
      sample_valid = 1'b1; sample_in = 10'd0;
      step();
      sample_valid = 1'b0;
      wait_ps(1100, n, ok);
      step();
      ones = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (pdm_out) ones++;
      end
      checks++;
      if (ones != 0) begin errors++; $display("FAIL sd_zero: got %0d ones expected 0", ones); end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      enable = 1'b0; enable4 = 1'b0;
      sample_valid = 1'b0; sample_valid4 = 1'b0;
      sample_in = '0; sample_in4 = '0;
      step();
      step();
      rst = 1'b0;
      step();
      test_reset();
      test_duty();
      test_update_boundary();
      test_overrun();
      test_prescale();
      test_sd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
